// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the RV32I writeback stage.
package wb_stage_pkg;

    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned WB_ADDR_W = 5;
    localparam int unsigned WB_CNT_W  = 64;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_IMM  = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Contents of the MEM/WB register apart from its valid/done flags.
    typedef struct packed {
        logic                 rd_wr;
        logic [WB_ADDR_W-1:0] rd_addr;
        logic                 misalign;
        logic [WB_DATA_W-1:0] data;
    } mem_wb_t;

    // Zero-extended register-address compare used for the x0 checks.
    function automatic logic is_x0(input logic [WB_ADDR_W-1:0] addr);
        return (addr == '0);
    endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data formatter: selects byte/half from the raw memory word, extends
// it to 32 bits and flags accesses that cannot retire (misaligned or an
// undefined load funct3).
module wb_stage_load_align
    import wb_stage_pkg::*;
(
    input  logic [2:0]           funct3,
    input  logic [1:0]           byte_off,
    input  logic [WB_DATA_W-1:0] rdata,
    output logic [WB_DATA_W-1:0] data,
    output logic                 misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection from the effective address low bits.
    always_comb begin
        byte_sel = rdata[8*byte_off +: 8];
        half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend per load type; anything that cannot retire yields zero data.
    always_comb begin
        data     = '0;
        misalign = 1'b0;
        unique case (funct3)
            F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU: data = {24'h0, byte_sel};
            F3_LH: begin
                misalign = byte_off[0];
                data     = {{16{half_sel[15]}}, half_sel};
            end
            F3_LHU: begin
                misalign = byte_off[0];
                data     = {16'h0, half_sel};
            end
            F3_LW: begin
                misalign = (byte_off != 2'b00);
                data     = rdata;
            end
            default: misalign = 1'b1;
        endcase
        if (misalign) begin
            data = '0;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: MEM/WB register, writeback source select, single
// regfile write per retiring instruction, forwarding view and instret.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned DATA_W = WB_DATA_W,
    parameter int unsigned ADDR_W = WB_ADDR_W,
    parameter int unsigned CNT_W  = WB_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              mem_valid_i,
    input  logic              mem_rd_wr_i,
    input  logic [ADDR_W-1:0] mem_rd_addr_i,
    input  logic [1:0]        mem_wb_sel_i,
    input  logic [2:0]        mem_ld_funct3_i,
    input  logic [1:0]        mem_byte_off_i,
    input  logic [DATA_W-1:0] mem_alu_data_i,
    input  logic [DATA_W-1:0] mem_ld_rdata_i,
    input  logic [DATA_W-1:0] mem_pc4_i,
    input  logic [DATA_W-1:0] mem_imm_i,
    output logic              regs_wr_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              fwd_valid_o,
    output logic              ld_misalign_o,
    output logic [CNT_W-1:0]  instret_o
);

    logic [DATA_W-1:0] ld_data;
    logic              ld_misalign;
    logic              is_load;
    mem_wb_t           entry_d;
    mem_wb_t           entry_q;
    logic              valid_q;
    logic              done_q;
    logic [CNT_W-1:0]  count_q;
    logic              retire;
    logic              rd_is_x0;

    wb_stage_load_align u_load_align (
        .funct3   (mem_ld_funct3_i),
        .byte_off (mem_byte_off_i),
        .rdata    (mem_ld_rdata_i),
        .data     (ld_data),
        .misalign (ld_misalign)
    );

    // Writeback source select on the MEM side so only the result is registered.
    always_comb begin
        is_load          = (wb_sel_e'(mem_wb_sel_i) == WB_LOAD);
        entry_d.rd_wr    = mem_rd_wr_i;
        entry_d.rd_addr  = mem_rd_addr_i;
        entry_d.misalign = is_load & ld_misalign;
        entry_d.data     = mem_alu_data_i;
        unique case (wb_sel_e'(mem_wb_sel_i))
            WB_ALU:  entry_d.data = mem_alu_data_i;
            WB_LOAD: entry_d.data = ld_data;
            WB_PC4:  entry_d.data = mem_pc4_i;
            WB_IMM:  entry_d.data = mem_imm_i;
            default: entry_d.data = mem_alu_data_i;
        endcase
    end

    // MEM/WB register; a stall freezes everything, including a pending flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            entry_q <= '0;
        end else if (!stall_i) begin
            valid_q <= mem_valid_i & ~flush_i;
            done_q  <= 1'b0;
            entry_q <= entry_d;
        end else if (valid_q) begin
            done_q  <= 1'b1;
        end
    end

    // The first held cycle of a well-formed entry is the retirement cycle.
    always_comb begin
        rd_is_x0 = is_x0(entry_q.rd_addr);
        retire   = valid_q & ~done_q & ~entry_q.misalign;
    end

    // Retired-instruction counter, free-running modulo 2^CNT_W.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (retire) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Regfile, forwarding and status outputs; instret includes the current retiree.
    always_comb begin
        regs_wr_en_o  = retire & entry_q.rd_wr & ~rd_is_x0;
        fwd_valid_o   = valid_q & entry_q.rd_wr & ~entry_q.misalign & ~rd_is_x0;
        ld_misalign_o = valid_q & entry_q.misalign;
        rd_addr_o     = valid_q ? entry_q.rd_addr : '0;
        rd_data_o     = (valid_q && !rd_is_x0) ? entry_q.data : '0;
        instret_o     = count_q + {{(CNT_W-1){1'b0}}, retire};
    end

endmodule
